// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Purpose  : Per-button synchroniser + counter debouncer producing a clean
//             level, one-cycle press/release strobes and a sticky pending
//             flag that software clears per bit.
//  Revision : 1.0  - initial release
// ============================================================================
module button_conditioner #(
    parameter int          BUTTONCOUNT     = 4,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic        ACTIVE_LOW      = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BUTTONCOUNT-1:0] buttons_async,
    output logic [BUTTONCOUNT-1:0] buttons,
    output logic [BUTTONCOUNT-1:0] press_pulse,
    output logic [BUTTONCOUNT-1:0] release_pulse,
    output logic [BUTTONCOUNT-1:0] pending,
    input  logic [BUTTONCOUNT-1:0] pending_clear
);

    // Counter only ever reaches DEBOUNCE_CYCLES-1, so clog2 bits suffice.
    localparam int                c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 16'd1);

    logic [BUTTONCOUNT-1:0] w_raw;
    logic [BUTTONCOUNT-1:0] r_s1;
    logic [BUTTONCOUNT-1:0] r_s2;
    logic [BUTTONCOUNT-1:0] r_pending;

    // Polarity normalisation so everything downstream is "1 = pressed".
    assign w_raw = ACTIVE_LOW ? ~buttons_async : buttons_async;

    // Two-flop synchroniser; only r_s2 is safe to use.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    // Per-bit debouncer, fully independent counters.
    for (genvar i = 0; i < BUTTONCOUNT; i++) begin : g_bit
        logic [c_cnt_w-1:0] r_cnt;
        logic               r_stb;
        logic               r_press;
        logic               r_release;

        // Count consecutive disagreement with the stable level; flip and strobe at the limit.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt     <= '0;
                r_stb     <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                if (r_s2[i] == r_stb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_max) begin
                    r_stb     <= r_s2[i];
                    r_cnt     <= '0;
                    r_press   <= r_s2[i];
                    r_release <= ~r_s2[i];
                end else begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end
        end

        assign buttons[i]       = r_stb;
        assign press_pulse[i]   = r_press;
        assign release_pulse[i] = r_release;
    end

    // Sticky pending flag: a press strobe beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~pending_clear) | press_pulse;
        end
    end

    assign pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_conditioner
//  Purpose  : Directed self-checking bench for button_conditioner with
//             DEBOUNCE_CYCLES=4 (active-high and active-low instances).
//  Revision : 1.0  - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ba;
    logic [3:0] clr;
    logic [3:0] btn, prs, rel, pnd;

    logic [0:0] b_pin;
    logic [0:0] b_clr;
    logic [0:0] b_btn, b_prs, b_rel, b_pnd;

    int checks   = 0;
    int failures = 0;
    int press_cnt [4];
    int rel_cnt   [4];
    bit glitch_seen;
    bit b_seen;

    button_conditioner #(
        .BUTTONCOUNT    (4),
        .DEBOUNCE_CYCLES(16'd4),
        .ACTIVE_LOW     (1'b0)
    ) u_dut (
        .clk          (clk),
        .reset        (rst),
        .buttons_async(ba),
        .buttons      (btn),
        .press_pulse  (prs),
        .release_pulse(rel),
        .pending      (pnd),
        .pending_clear(clr)
    );

    button_conditioner #(
        .BUTTONCOUNT    (1),
        .DEBOUNCE_CYCLES(16'd4),
        .ACTIVE_LOW     (1'b1)
    ) u_dut_low (
        .clk          (clk),
        .reset        (rst),
        .buttons_async(b_pin),
        .buttons      (b_btn),
        .press_pulse  (b_prs),
        .release_pulse(b_rel),
        .pending      (b_pnd),
        .pending_clear(b_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then observe outputs 1ns later and update tallies.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (prs[i]) press_cnt[i]++;
            if (rel[i]) rel_cnt[i]++;
        end
        if (btn[2] | prs[2] | pnd[2]) glitch_seen = 1'b1;
        if (b_btn[0] | b_prs[0] | b_pnd[0]) b_seen = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    function automatic int total_pulses();
        int s = 0;
        for (int i = 0; i < 4; i++) s += press_cnt[i] + rel_cnt[i];
        return s;
    endfunction

    initial begin
        logic [8:0] seq;
        int         snap;
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
        end
        glitch_seen = 1'b0;
        b_seen      = 1'b0;
        rst   = 1'b1;
        ba    = 4'b0000;
        clr   = 4'b0000;
        b_pin = 1'b1;
        b_clr = 1'b0;

        // Reset state
        ticks(3);
        check("rst_buttons", 32'(btn), 32'h0);
        check("rst_press",   32'(prs), 32'h0);
        check("rst_release", 32'(rel), 32'h0);
        check("rst_pending", 32'(pnd), 32'h0);
        rst = 1'b0;
        ticks(2);

        // Clean press on bit 0: change before edge k -> visible after k+5
        ba[0] = 1'b1;
        ticks(5);
        check("clean_btn_early", 32'(btn[0]), 32'h0);
        tick();
        check("clean_btn",       32'(btn[0]), 32'h1);
        check("clean_press",     32'(prs[0]), 32'h1);
        check("clean_pnd_early", 32'(pnd[0]), 32'h0);
        tick();
        check("clean_press_low", 32'(prs[0]), 32'h0);
        check("clean_pending",   32'(pnd[0]), 32'h1);

        // Bounce on bit 1: 1,0,1,1,0,1,1,1,1 (element n at bit n)
        seq = 9'b111101101;
        for (int n = 0; n < 9; n++) begin
            ba[1] = seq[n];
            tick();
        end
        tick();
        check("bounce_btn_early", 32'(btn[1]), 32'h0);
        check("bounce_no_early",  32'(press_cnt[1]), 32'h0);
        tick();
        check("bounce_press",     32'(prs[1]), 32'h1);
        ticks(5);
        check("bounce_one_press", 32'(press_cnt[1]), 32'h1);
        check("bounce_bit0_kept", 32'(btn[0]), 32'h1);

        // Glitch rejection on bit 2: three cycles high never reach the output
        glitch_seen = 1'b0;
        ba[2] = 1'b1;
        ticks(3);
        ba[2] = 1'b0;
        ticks(8);
        check("glitch_seen",  32'(glitch_seen), 32'h0);
        check("glitch_press", 32'(press_cnt[2]), 32'h0);

        // Clear, release, and clear colliding with a press strobe
        check("clr_pnd_before", 32'(pnd[0]), 32'h1);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        check("clr_pnd_after", 32'(pnd[0]), 32'h0);
        ba[0] = 1'b0;
        ticks(5);
        check("rel_early",   32'(rel[0]), 32'h0);
        tick();
        check("rel_pulse",   32'(rel[0]), 32'h1);
        check("rel_btn",     32'(btn[0]), 32'h0);
        check("rel_no_pnd",  32'(pnd[0]), 32'h0);
        tick();
        check("rel_low",     32'(rel[0]), 32'h0);
        check("rel_count",   32'(rel_cnt[0]), 32'h1);
        ba[0] = 1'b1;
        ticks(6);
        check("repress_pulse", 32'(prs[0]), 32'h1);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        check("collide_set_wins", 32'(pnd[0]), 32'h1);

        // Reset mid-count on bit 3 (cnt=2) aborts without any pulse
        ba[3] = 1'b1;
        ticks(4);
        rst   = 1'b1;
        ba    = 4'b0000;
        ticks(2);
        check("midrst_btn",   32'(btn), 32'h0);
        check("midrst_press", 32'(prs), 32'h0);
        check("midrst_pnd",   32'(pnd), 32'h0);
        rst  = 1'b0;
        snap = total_pulses();
        ticks(10);
        check("midrst_no_pulse", 32'(total_pulses()), 32'(snap));
        check("midrst_btn3",     32'(btn[3]), 32'h0);

        // Pin held through reset: counting from the first edge that samples
        // reset low, the press appears after the fifth edge following it.
        rst   = 1'b1;
        ba[0] = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(5);
        check("held_press_early", 32'(prs[0]), 32'h0);
        tick();
        check("held_press", 32'(prs[0]), 32'h1);
        check("held_btn",   32'(btn[0]), 32'h1);

        // Active-low instance: idle-high pin never produced anything
        check("low_idle_quiet", 32'(b_seen), 32'h0);
        b_pin = 1'b0;
        ticks(5);
        check("low_btn_early", 32'(b_btn), 32'h0);
        tick();
        check("low_btn",   32'(b_btn), 32'h1);
        check("low_press", 32'(b_prs), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
